// File: rtl/dac_interp_out.sv
// DAC output stage: pops samples from a FIFO and upsamples by 2^US_SHIFT.
// Define DAC_INTERP_LINEAR_EN for linear interpolation; otherwise zero-order hold.
module dac_interp_out #(
    parameter int DATA_WIDTH = 14,
    parameter int US_SHIFT   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] dac_data,
    output logic                  dac_valid,
    output logic                  underrun,
    output logic [1:0]            dbg_state
);

    // Handshake: fifo_rd_en is a pop request; fifo_rd_data is valid exactly one
    // cycle later (rd_pend_q=1), and the sample pair shifts on that cycle's edge.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2,
        UNDER = 2'd3
    } state_t;

    localparam logic [DATA_WIDTH-1:0] MIDSCALE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [US_SHIFT-1:0]   PH_LAST  = '1;
    localparam logic [US_SHIFT-1:0]   PH_PRE   = PH_LAST - US_SHIFT'(1);

    state_t                  state_q, state_d;
    logic [US_SHIFT-1:0]     phase_q, phase_d;
    logic                    prime_cnt_q, prime_cnt_d;
    logic                    rd_pend_q;
    logic [DATA_WIDTH-1:0]   prev_q, curr_q;
    logic [DATA_WIDTH-1:0]   dac_data_q, dac_data_d;
    logic                    dac_valid_q, dac_valid_d;
    logic                    underrun_q, underrun_d;
    logic [DATA_WIDTH-1:0]   interp;

`ifdef DAC_INTERP_LINEAR_EN
    localparam int PW = DATA_WIDTH + US_SHIFT + 2;

    logic signed [DATA_WIDTH:0] diff;
    logic signed [US_SHIFT:0]   phase_s;
    logic signed [PW-1:0]       prod;
    logic [DATA_WIDTH-1:0]      delta;

    // The result always lies between prev and curr, so modulo-2^W addition is exact.
    always_comb begin
        diff    = $signed({1'b0, curr_q}) - $signed({1'b0, prev_q});
        phase_s = $signed({1'b0, phase_q});
        prod    = PW'(diff) * PW'(phase_s);
        delta   = DATA_WIDTH'(prod >>> US_SHIFT);
        interp  = prev_q + delta;
    end
`else
    always_comb begin
        interp = prev_q;
    end
`endif

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        prime_cnt_d = prime_cnt_q;
        fifo_rd_en  = 1'b0;
        if (!ena) begin
            state_d     = IDLE;
            phase_d     = '0;
            prime_cnt_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d     = PRIME;
                    phase_d     = '0;
                    prime_cnt_d = 1'b0;
                end
                PRIME: begin
                    fifo_rd_en = !rd_pend_q && !fifo_empty;
                    if (rd_pend_q) begin
                        if (prime_cnt_q) begin
                            state_d = RUN;
                            phase_d = '0;
                        end else begin
                            prime_cnt_d = 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Reading at N-2 lands the next sample exactly as the segment ends.
                    fifo_rd_en = (phase_q == PH_PRE) && !fifo_empty;
                    phase_d    = phase_q + US_SHIFT'(1);
                    if ((phase_q == PH_LAST) && !rd_pend_q) begin
                        state_d = UNDER;
                    end
                end
                UNDER: begin
                    fifo_rd_en = !rd_pend_q && !fifo_empty;
                    if (rd_pend_q) begin
                        state_d = RUN;
                        phase_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        dac_data_d  = MIDSCALE;
        dac_valid_d = 1'b0;
        underrun_d  = 1'b0;
        if (ena) begin
            unique case (state_q)
                RUN: begin
                    dac_data_d  = interp;
                    dac_valid_d = 1'b1;
                end
                UNDER: begin
                    dac_data_d = curr_q;
                    // First UNDER cycle is the only one whose predecessor output was valid.
                    underrun_d = dac_valid_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            prime_cnt_q <= 1'b0;
            rd_pend_q   <= 1'b0;
            prev_q      <= '0;
            curr_q      <= '0;
            dac_data_q  <= MIDSCALE;
            dac_valid_q <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            prime_cnt_q <= prime_cnt_d;
            rd_pend_q   <= fifo_rd_en;
            if (rd_pend_q) begin
                prev_q <= curr_q;
                curr_q <= fifo_rd_data;
            end
            dac_data_q  <= dac_data_d;
            dac_valid_q <= dac_valid_d;
            underrun_q  <= underrun_d;
        end
    end

    assign dac_data  = dac_data_q;
    assign dac_valid = dac_valid_q;
    assign underrun  = underrun_q;
    assign dbg_state = state_q;

    a_rd_legal : assert property (@(posedge clk) disable iff (!rst_n)
        fifo_rd_en |-> (ena && !fifo_empty && !rd_pend_q));
    a_under_invalid : assert property (@(posedge clk) disable iff (!rst_n)
        underrun |-> !dac_valid);

endmodule

// File: tb/tb_dac_interp_out.sv
// Bench for dac_interp_out: FIFO model, pair-wise reference model and scoreboard.
module tb_dac_interp_out;

    localparam int DW  = 14;
    localparam int USH = 2;
    localparam int N   = 1 << USH;
    localparam logic [DW-1:0] MID = DW'(1 << (DW - 1));

    logic          clk;
    logic          rst_n;
    logic          ena;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_rd_en;
    logic [DW-1:0] dac_data;
    logic          dac_valid;
    logic          underrun;
    logic [1:0]    dbg_state;

    int n_tests;
    int n_fail;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_q[$];
    logic          pend_valid;
    logic [DW-1:0] pend_data;
    logic          hold_empty;
    logic          have_last;
    logic [DW-1:0] last_s;
    int            n_valid;

    dac_interp_out #(
        .DATA_WIDTH(DW),
        .US_SHIFT  (USH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .fifo_empty  (fifo_empty),
        .fifo_rd_data(fifo_rd_data),
        .fifo_rd_en  (fifo_rd_en),
        .dac_data    (dac_data),
        .dac_valid   (dac_valid),
        .underrun    (underrun),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output for phase ph of the segment running from sample p0 to sample p1.
    function automatic logic [DW-1:0] model_out(input int p0, input int p1, input int ph);
        int num;
        int q;
        num = (p1 - p0) * ph;
        q   = num / N;
        if ((num % N) != 0 && num < 0) q = q - 1;
`ifndef DAC_INTERP_LINEAR_EN
        q = 0;
`endif
        return DW'(p0 + q);
    endfunction

    task automatic push_sample(input logic [DW-1:0] s);
        fifo_q.push_back(s);
        if (have_last) begin
            for (int ph = 0; ph < N; ph++) exp_q.push_back(model_out(int'(last_s), int'(s), ph));
        end
        last_s    = s;
        have_last = 1'b1;
    endtask

    task automatic new_session;
        exp_q.delete();
        have_last = 1'b0;
        n_valid   = 0;
    endtask

    // One clock: drive at the falling edge, model the FIFO, check registered outputs.
    task automatic step(input logic en);
        logic [DW-1:0] exp_v;
        @(negedge clk);
        ena = en;
        if (pend_valid) begin
            fifo_rd_data = pend_data;
            pend_valid   = 1'b0;
        end
        fifo_empty = (fifo_q.size() == 0) || hold_empty;
        #1;
        if (fifo_rd_en === 1'b1) begin
            n_tests++;
            if (fifo_empty || !ena) begin
                n_fail++;
                $display("FAIL rd_en_legal: fifo_rd_en=1 with fifo_empty=%0b ena=%0b, required 0", fifo_empty, ena);
            end else begin
                pend_data  = fifo_q.pop_front();
                pend_valid = 1'b1;
            end
        end
        if (dac_valid === 1'b1) begin
            n_tests++;
            n_valid++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_extra: dac_data=%0d valid with nothing expected", dac_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (dac_data !== exp_v) begin
                    n_fail++;
                    $display("FAIL scoreboard: dac_data=%0d, expected %0d", dac_data, exp_v);
                end
            end
        end
        if (underrun === 1'b1) begin
            n_tests++;
            if (dac_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL underrun_valid: dac_valid=%0b during underrun, required 0", dac_valid);
            end
        end
    endtask

    task automatic check_idle_out(input string name);
        n_tests++;
        if (dac_data !== MID || dac_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: dac_data=%0d dac_valid=%0b, required %0d/0", name, dac_data, dac_valid, MID);
        end
    endtask

    task automatic check_done(input string name, input int want_valid);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: %0d expected outputs never appeared, required 0", name, exp_q.size());
        end
        if (want_valid >= 0) begin
            n_tests++;
            if (n_valid != want_valid) begin
                n_fail++;
                $display("FAIL %s_count: %0d valid outputs, required %0d", name, n_valid, want_valid);
            end
        end
    endtask

    task automatic end_session;
        step(1'b0);
        step(1'b0);
        check_idle_out("session_end_idle");
        fifo_q.delete();
        pend_valid = 1'b0;
        hold_empty = 1'b0;
        new_session();
    endtask

    task automatic test_reset;
        ena        = 1'b1;
        fifo_empty = 1'b0;
        rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_idle_out("reset_out");
        n_tests++;
        if (underrun !== 1'b0 || fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: underrun=%0b fifo_rd_en=%0b, required 0/0", underrun, fifo_rd_en);
        end
        ena        = 1'b0;
        fifo_empty = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0);
        step(1'b0);
        check_idle_out("post_reset_idle");
    endtask

    task automatic test_ramp;
        int under_cnt;
        new_session();
        under_cnt = 0;
        push_sample(14'd1000);
        push_sample(14'd2000);
        push_sample(14'd3000);
        for (int c = 0; c < 40; c++) begin
            step(1'b1);
            if (underrun === 1'b1) begin
                under_cnt++;
                n_tests++;
                if (dac_data !== 14'd3000) begin
                    n_fail++;
                    $display("FAIL ramp_hold: dac_data=%0d during underrun, required 3000", dac_data);
                end
            end
        end
        check_done("ramp", 2 * N);
        n_tests++;
        if (under_cnt != 1) begin
            n_fail++;
            $display("FAIL ramp_underrun_pulses: %0d, required 1", under_cnt);
        end
        push_sample(14'd4000);
        for (int c = 0; c < 30; c++) begin
            step(1'b1);
            if (underrun === 1'b1) begin
                under_cnt++;
                n_tests++;
                if (dac_data !== 14'd4000) begin
                    n_fail++;
                    $display("FAIL refill_hold: dac_data=%0d during underrun, required 4000", dac_data);
                end
            end
        end
        check_done("refill", 3 * N);
        n_tests++;
        if (under_cnt != 2) begin
            n_fail++;
            $display("FAIL refill_underrun_pulses: %0d, required 2", under_cnt);
        end
        end_session();
    endtask

    task automatic test_falling;
        logic [DW-1:0] a_tab [2];
        logic [DW-1:0] b_tab [2];
        a_tab[0] = 14'd2000; b_tab[0] = 14'd1000;
        a_tab[1] = 14'd1001; b_tab[1] = 14'd1000;
        for (int t = 0; t < 2; t++) begin
            new_session();
            push_sample(a_tab[t]);
            push_sample(b_tab[t]);
            for (int c = 0; c < 25; c++) step(1'b1);
            check_done("falling", N);
            end_session();
        end
    endtask

    task automatic test_random;
        int len;
        int idx;
        for (int s = 0; s < 5; s++) begin
            new_session();
            len = $urandom_range(3, 9);
            idx = 0;
            for (int c = 0; c < 500; c++) begin
                hold_empty = ($urandom_range(0, 4) == 0);
                if (idx < len && $urandom_range(0, 2) == 0) begin
                    push_sample(DW'($urandom_range(0, (1 << DW) - 1)));
                    idx++;
                end
                step(1'b1);
                if (idx == len && exp_q.size() == 0 && fifo_q.size() == 0) break;
            end
            hold_empty = 1'b0;
            repeat (8) step(1'b1);
            check_done("random", (len - 1) * N);
            end_session();
        end
    endtask

    task automatic test_reset_mid_run;
        new_session();
        push_sample(14'd1000);
        push_sample(14'd5000);
        push_sample(14'd9000);
        push_sample(14'd12000);
        for (int c = 0; c < 40 && n_valid < 2; c++) step(1'b1);
        n_tests++;
        if (n_valid != 2) begin
            n_fail++;
            $display("FAIL midrun_reach: %0d outputs before reset point, required 2", n_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_out("midrun_reset_out");
        n_tests++;
        if (fifo_rd_en !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset_rd: fifo_rd_en=%0b, required 0", fifo_rd_en);
        end
        fifo_q.delete();
        pend_valid = 1'b0;
        new_session();
        step(1'b1);
        step(1'b1);
        rst_n = 1'b1;
        push_sample(14'd7000);
        push_sample(14'd6000);
        push_sample(14'd6500);
        for (int c = 0; c < 40; c++) begin
            step(1'b1);
            if (exp_q.size() == 0 && fifo_q.size() == 0) break;
        end
        repeat (6) step(1'b1);
        check_done("midrun_reprime", 2 * N);
        end_session();
    endtask

    task automatic test_ena_drop;
        new_session();
        push_sample(14'd11);
        push_sample(14'd22);
        push_sample(14'd33);
        for (int c = 0; c < 10 && !pend_valid; c++) step(1'b1);
        n_tests++;
        if (!pend_valid) begin
            n_fail++;
            $display("FAIL ena_drop_read: no pop issued, required one");
        end
        step(1'b0);
        step(1'b0);
        check_idle_out("ena_drop_idle");
        repeat (5) step(1'b0);
        n_tests++;
        if (fifo_q.size() != 2) begin
            n_fail++;
            $display("FAIL ena_drop_consumed: %0d samples left, required 2", fifo_q.size());
        end
        end_session();
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b0;
        ena          = 1'b0;
        fifo_empty   = 1'b1;
        fifo_rd_data = '0;
        pend_valid   = 1'b0;
        pend_data    = '0;
        hold_empty   = 1'b0;
        have_last    = 1'b0;
        last_s       = '0;
        n_valid      = 0;
        test_reset();
        test_ramp();
        test_falling();
        test_random();
        test_reset_mid_run();
        test_ena_drop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dac_interp_out.md
DAC_INTERP_OUT -- requirements
Module: dac_interp_out

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 14, giving the sample width (unsigned offset-binary).
REQ-002 The block SHALL have parameter US_SHIFT, default 2, setting the upsampling factor N = 2^US_SHIFT; legal range is 1..6.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port ena, input, 1 bit: run enable.
REQ-006 Port fifo_empty, input, 1 bit: the source FIFO is empty.
REQ-007 Port fifo_rd_data, input, DATA_WIDTH bits: FIFO read data, valid the cycle after fifo_rd_en.
REQ-008 Port fifo_rd_en, output, 1 bit: FIFO pop request.
REQ-009 Port dac_data, output, DATA_WIDTH bits: registered DAC sample.
REQ-010 Port dac_valid, output, 1 bit: dac_data carries a fresh interpolated sample.
REQ-011 Port underrun, output, 1 bit: one-cycle pulse on FIFO starvation.

Function
REQ-012 The FSM SHALL have four states: IDLE, PRIME, RUN and UNDER.
- Internal registers: prev, curr, phase (0..N-1), rd_pend (fifo_rd_en delayed 1 cycle).
REQ-013 On every cycle with rd_pend=1, the block SHALL shift its sample pair: prev<=curr, curr<=fifo_rd_data.
REQ-014 fifo_rd_en SHALL only assert when fifo_empty=0 and ena=1; fifo_rd_en is a combinational decode of registered state and fifo_empty.
REQ-015 IDLE: dac_valid=0 and dac_data=2^(DATA_WIDTH-1).
- ena=1 -> PRIME.
REQ-016 PRIME: pop exactly two samples, one read at a time (rd_en only when rd_pend=0).
- After the second shift: RUN with phase=0.
REQ-017 RUN: dac_data SHALL be registered as prev + floor(((curr-prev)*phase) / N).
- Difference is signed, DATA_WIDTH+1 bits; arithmetic shift right by US_SHIFT.
- Result always lies between prev and curr, so truncation to DATA_WIDTH is lossless.
- dac_valid=1; latency from state/phase to output is 1 cycle.
REQ-018 RUN: phase increments every cycle and wraps N-1 -> 0.
- fifo_rd_en asserts at phase=N-2 if fifo_empty=0, so the shift lands at the end of phase N-1.
REQ-019 RUN: if no read was issued at phase N-2 (FIFO empty), the block SHALL enter UNDER at the end of phase N-1.
- underrun pulses for 1 cycle.
- dac_data holds curr; dac_valid=0.
REQ-020 UNDER: when fifo_empty=0 and rd_pend=0, assert fifo_rd_en for 1 cycle.
- On the resulting shift: RUN with phase=0.
- FIFO going non-empty at phase N-1 does not rescue the segment; the underrun is already committed.
REQ-021 ena=0 in any state SHALL force IDLE on the next edge.
- A read in flight (rd_pend=1) is consumed and discarded.
- No fifo_rd_en is issued in the cycle ena=0.
REQ-022 ena and fifo_empty SHALL be sampled as synchronous to clk; no internal synchronisers.

Reset
REQ-023 rst_n=0 SHALL asynchronously force:
- state=IDLE, phase=0, prev=curr=0, rd_pend=0.
- dac_data=2^(DATA_WIDTH-1), dac_valid=0, underrun=0, fifo_rd_en=0.
REQ-024 Release of rst_n SHALL take effect on the next rising edge of clk; reset mid-RUN loses the held pair and requires a new PRIME.

Configuration
REQ-025 Macro DAC_INTERP_LINEAR_EN defined: RUN output is linear interpolation per REQ-017.
REQ-026 Macro DAC_INTERP_LINEAR_EN undefined: RUN output is zero-order hold (dac_data=prev on every phase); multiplier logic is absent.
- All handshake, state, underrun and timing behaviour is identical to the defined case.

Verification
REQ-027 With DATA_WIDTH=14, US_SHIFT=2, FIFO {1000,2000,3000}, ena=1: dac_data 1000,1250,1500,1750,2000,2250,... with dac_valid=1.
REQ-028 FIFO {2000,1000}: RUN outputs 2000,1750,1500,1250; FIFO {1001,1000}: outputs 1001,1000,1000,1000 (floor rounding).
REQ-029 FIFO empties after the third sample: underrun=1 for exactly 1 cycle, dac_data holds 3000, dac_valid=0; refill with 4000 -> RUN resumes at 3000,3250,...
REQ-030 Assert rst_n=0 mid-RUN at phase 2: same-cycle dac_data=8192, dac_valid=0, fifo_rd_en=0; after release, PRIME pops two new samples.
REQ-031 Drop ena while a read is in flight: IDLE next cycle, dac_data=8192, exactly one sample consumed, no further pops.
REQ-032 Rerun REQ-027 with DAC_INTERP_LINEAR_EN undefined: outputs 1000,1000,1000,1000,2000,2000,..., with identical fifo_rd_en timing.
